// File: rtl/sha_pad_pkg.sv
// Shared types and helpers for the SHA-2 stream padder.
package sha_pad_pkg;

  typedef enum logic [1:0] {FILL, PAD, EMIT, EXTRA} state_e;

  localparam logic [7:0] MARKER = 8'h80;

  // True when a marker at byte offset p still leaves room for the length field.
  function automatic logic last_word_fits(input int unsigned block_w, input int unsigned len_w,
                                          input int unsigned p);
    return p <= (block_w / 8 - len_w / 8 - 1);
  endfunction

endpackage

// File: rtl/sha_stream_padder_if.sv
// Message word stream in, padded block stream out.
interface sha_stream_padder_if #(
  parameter int unsigned BLOCK_W = 512,
  parameter int unsigned WORD_W  = 32
);
  logic               i_valid;
  logic               o_ready;
  logic [WORD_W-1:0]  i_data;
  logic               i_last;
  logic [2:0]         i_last_bytes;
  logic               o_blk_valid;
  logic               i_blk_ready;
  logic [BLOCK_W-1:0] o_blk;
  logic               o_blk_first;
  logic               o_blk_last;

  modport slave (
    input  i_valid, i_data, i_last, i_last_bytes, i_blk_ready,
    output o_ready, o_blk_valid, o_blk, o_blk_first, o_blk_last
  );

  modport master (
    output i_valid, i_data, i_last, i_last_bytes, i_blk_ready,
    input  o_ready, o_blk_valid, o_blk, o_blk_first, o_blk_last
  );
endinterface

// File: rtl/sha_pad_tail_word.sv
// Masks bytes past the message end and drops the 0x80 marker into the last word when it fits.
module sha_pad_tail_word
  import sha_pad_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_last_bytes,
  output logic [31:0] o_word,
  output logic        o_marker_next
);

  always_comb begin
    o_word        = i_word;
    o_marker_next = 1'b0;
    case (i_last_bytes)
      3'd0:    o_word = {MARKER, 24'h0};
      3'd1:    o_word = {i_word[31:24], MARKER, 16'h0};
      3'd2:    o_word = {i_word[31:16], MARKER, 8'h0};
      3'd3:    o_word = {i_word[31:8], MARKER};
      default: o_marker_next = 1'b1;
    endcase
  end

endmodule

// File: rtl/sha_stream_padder.sv
// SHA-2 message padder: packs 32-bit words into blocks and appends marker, zero fill and length.
module sha_stream_padder
  import sha_pad_pkg::*;
#(
  parameter int unsigned BLOCK_W = 512,
  parameter int unsigned LEN_W   = 64,
  parameter int unsigned WORD_W  = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  sha_stream_padder_if.slave  bus
);

  localparam int unsigned NW   = BLOCK_W / WORD_W;
  localparam int unsigned WP_W = $clog2(NW);
  localparam int unsigned P_W  = WP_W + 3;
  localparam int unsigned LW   = LEN_W / WORD_W;

  state_e                    r_state, w_state_nxt;
  logic [NW-1:0][WORD_W-1:0] r_buf;
  logic [WP_W-1:0]           r_wp, w_wp_nxt;
  logic [LEN_W-1:0]          r_len, w_len_add;
  logic [2:0]                r_last_bytes;
  logic                      r_marker_next, r_marker_pend, r_extra, r_blk_last, r_not_first;
  logic                      w_accept, w_wp_max, w_fits, w_marker_next;
  logic [P_W-1:0]            w_p;
  logic [31:0]               w_tail_word;

  sha_pad_tail_word u_tail (
    .i_word        (bus.i_data),
    .i_last_bytes  (bus.i_last_bytes),
    .o_word        (w_tail_word),
    .o_marker_next (w_marker_next)
  );

  assign w_accept  = bus.i_valid && bus.o_ready;
  assign w_wp_nxt  = r_wp + WP_W'(1);
  assign w_wp_max  = (r_wp == WP_W'(NW - 1));
  assign w_len_add = bus.i_last ? LEN_W'({bus.i_last_bytes, 3'b000}) : LEN_W'(WORD_W);
  assign w_p       = P_W'({r_wp, 2'b00}) + P_W'(r_last_bytes);
  assign w_fits    = last_word_fits(BLOCK_W, LEN_W, 32'(w_p));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= FILL;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FILL:    if (w_accept) begin
                 if (bus.i_last)    w_state_nxt = PAD;
                 else if (w_wp_max) w_state_nxt = EMIT;
               end
      PAD:     w_state_nxt = EMIT;
      EMIT:    if (bus.i_blk_ready) w_state_nxt = r_extra ? EXTRA : FILL;
      EXTRA:   w_state_nxt = EMIT;
      default: w_state_nxt = FILL;
    endcase
  end

  always_comb begin
    bus.o_ready     = i_rst_n && (r_state == FILL);
    bus.o_blk_valid = (r_state == EMIT);
    bus.o_blk       = r_buf;
    bus.o_blk_first = (r_state == EMIT) && !r_not_first;
    bus.o_blk_last  = (r_state == EMIT) && r_blk_last;
  end

  // Buffer is cleared on every handshake, so bytes past the marker are already zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_buf         <= '0;
      r_wp          <= '0;
      r_len         <= '0;
      r_last_bytes  <= '0;
      r_marker_next <= 1'b0;
      r_marker_pend <= 1'b0;
      r_extra       <= 1'b0;
      r_blk_last    <= 1'b0;
      r_not_first   <= 1'b0;
    end else begin
      unique case (r_state)
        FILL: if (w_accept) begin
          r_buf[~r_wp] <= bus.i_last ? w_tail_word : bus.i_data;
          r_len        <= r_len + w_len_add;
          if (bus.i_last) begin
            r_last_bytes  <= bus.i_last_bytes;
            r_marker_next <= w_marker_next;
          end else begin
            r_wp <= w_wp_nxt;
          end
        end
        PAD: begin
          if (r_marker_next && !w_wp_max) r_buf[~w_wp_nxt][WORD_W-1 -: 8] <= MARKER;
          if (w_fits) begin
            r_buf[LW-1:0] <= r_len;
            r_blk_last    <= 1'b1;
          end else begin
            r_extra       <= 1'b1;
            r_marker_pend <= r_marker_next && w_wp_max;
          end
        end
        EMIT: if (bus.i_blk_ready) begin
          r_buf       <= '0;
          r_wp        <= '0;
          r_not_first <= !r_blk_last;
          r_blk_last  <= 1'b0;
          if (r_blk_last) r_len <= '0;
        end
        EXTRA: begin
          r_buf[NW-1][WORD_W-1] <= r_marker_pend;
          r_buf[LW-1:0]         <= r_len;
          r_blk_last            <= 1'b1;
          r_extra               <= 1'b0;
          r_marker_pend         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  a_last_bytes_legal: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (bus.i_valid && bus.o_ready && bus.i_last) |-> (bus.i_last_bytes <= 3'd4));

endmodule

// File: tb/tb_sha_stream_padder.sv
// Bench for sha_stream_padder: SHA-256 and SHA-512 instances against a byte-level padding model.
module tb_sha_stream_padder;

  typedef struct {
    logic [1023:0] blk;
    bit            first;
    bit            last;
  } blk_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;

  logic [7:0] msg [0:255];
  blk_t       got0[$];
  blk_t       got1[$];
  blk_t       expq[$];
  blk_t       c0, c1;

  always #5 clk = ~clk;

  sha_stream_padder_if #(.BLOCK_W(512), .WORD_W(32))  bus0 ();
  sha_stream_padder_if #(.BLOCK_W(1024), .WORD_W(32)) bus1 ();

  sha_stream_padder #(.BLOCK_W(512), .LEN_W(64), .WORD_W(32)) dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus0.slave)
  );

  sha_stream_padder #(.BLOCK_W(1024), .LEN_W(128), .WORD_W(32)) dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus1.slave)
  );

  // Handshakes seen at a falling edge complete on the following rising edge.
  always @(negedge clk) begin
    if (bus0.o_blk_valid === 1'b1 && bus0.i_blk_ready === 1'b1) begin
      c0.blk = 1024'(bus0.o_blk); c0.first = bus0.o_blk_first; c0.last = bus0.o_blk_last;
      got0.push_back(c0);
    end
    if (bus1.o_blk_valid === 1'b1 && bus1.i_blk_ready === 1'b1) begin
      c1.blk = bus1.o_blk; c1.first = bus1.o_blk_first; c1.last = bus1.o_blk_last;
      got1.push_back(c1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int qsize(input bit sel);
    return sel ? got1.size() : got0.size();
  endfunction

  function automatic blk_t qget(input bit sel, input int i);
    return sel ? got1[i] : got0[i];
  endfunction

  task automatic set_in(input bit sel, input bit v, input logic [31:0] d, input bit l,
                        input logic [2:0] lb);
    if (!sel) begin
      bus0.i_valid = v; bus0.i_data = d; bus0.i_last = l; bus0.i_last_bytes = lb;
    end else begin
      bus1.i_valid = v; bus1.i_data = d; bus1.i_last = l; bus1.i_last_bytes = lb;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the word is taken.
  task automatic send_word(input bit sel, input logic [31:0] d, input bit l, input logic [2:0] lb);
    int n = 0;
    bit done = 0;
    set_in(sel, 1'b1, d, l, lb);
    while (!done && n < 100) begin
      done = ((sel ? bus1.o_ready : bus0.o_ready) === 1'b1);
      @(negedge clk);
      n++;
    end
    set_in(sel, 1'b0, 32'h0, 1'b0, 3'd0);
    if (!done) begin
      total++;
      $display("FAIL send_word timeout: o_ready=0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic send_msg(input bit sel, input int len);
    int nw;
    logic [31:0] w;
    logic [2:0] lb;
    bit last;
    if (sel) got1.delete(); else got0.delete();
    nw = (len == 0) ? 1 : (len + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      last = (k == nw - 1);
      for (int b = 0; b < 4; b++)
        w[31 - 8*b -: 8] = (4*k + b < len) ? msg[4*k + b] : 8'($urandom);
      lb = last ? 3'(len - 4*k) : 3'($urandom_range(0, 4));
      send_word(sel, w, last, lb);
      if (!last && $urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  // Reference: message, 0x80, zeros, big-endian bit length, cut into blocks.
  task automatic build_expected(input int len, input int bb, input int lb);
    logic [7:0] pad [0:639];
    logic [63:0] bitlen;
    int nblk;
    blk_t e;
    expq.delete();
    nblk = (len + 1 + lb + bb - 1) / bb;
    for (int i = 0; i < nblk*bb; i++) pad[i] = (i < len) ? msg[i] : 8'h00;
    pad[len] = 8'h80;
    bitlen = 64'(len) * 64'd8;
    for (int k = 0; k < 8; k++) pad[nblk*bb - 1 - k] = bitlen[8*k +: 8];
    for (int b = 0; b < nblk; b++) begin
      e.blk = '0;
      for (int j = 0; j < bb; j++) e.blk[8*(bb - 1 - j) +: 8] = pad[b*bb + j];
      e.first = (b == 0);
      e.last  = (b == nblk - 1);
      expq.push_back(e);
    end
  endtask

  task automatic check_msg(input bit sel, input int len, input string name);
    int n = 0;
    int wi;
    blk_t g;
    build_expected(len, sel ? 128 : 64, sel ? 16 : 8);
    while (qsize(sel) < expq.size() && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (qsize(sel) !== expq.size())
      $display("FAIL %s count: got %0d blocks, required %0d", name, qsize(sel), expq.size());
    else passed++;
    for (int i = 0; i < expq.size() && i < qsize(sel); i++) begin
      g = qget(sel, i);
      total++;
      if (g.blk !== expq[i].blk) begin
        wi = 0;
        while (wi < 31 && g.blk[32*wi +: 32] === expq[i].blk[32*wi +: 32]) wi++;
        $display("FAIL %s blk%0d bits[%0d+:32]: got %h, required %h", name, i, 32*wi,
                 g.blk[32*wi +: 32], expq[i].blk[32*wi +: 32]);
      end else passed++;
      total++;
      if ({g.first, g.last} !== {expq[i].first, expq[i].last})
        $display("FAIL %s blk%0d first/last: got %b%b, required %b%b", name, i, g.first, g.last,
                 expq[i].first, expq[i].last);
      else passed++;
    end
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if ({bus0.o_ready, bus0.o_blk_valid, bus0.o_blk_first, bus0.o_blk_last} !== 4'b0000)
      $display("FAIL %s flags: got rdy/vld/first/last=%b%b%b%b, required 0000", name,
               bus0.o_ready, bus0.o_blk_valid, bus0.o_blk_first, bus0.o_blk_last);
    else passed++;
    total++;
    if (bus0.o_blk !== 512'h0)
      $display("FAIL %s o_blk: got nonzero top word %h, required 0", name, bus0.o_blk[511:480]);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(0, 1'b0, 32'h0, 1'b0, 3'd0);
    set_in(1, 1'b0, 32'h0, 1'b0, 3'd0);
    bus0.i_blk_ready = 1'b1;
    bus1.i_blk_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus0.o_ready !== 1'b1 || bus1.o_ready !== 1'b1)
      $display("FAIL reset_release o_ready: got %b/%b, required 1/1", bus0.o_ready, bus1.o_ready);
    else passed++;
  endtask

  task automatic test_abc();
    logic [511:0] e_abc;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(0, 3);
    total++;
    if (bus0.o_blk_valid !== 1'b0)
      $display("FAIL abc latency pad cycle: o_blk_valid got %b, required 0", bus0.o_blk_valid);
    else passed++;
    @(negedge clk);
    total++;
    if (bus0.o_blk_valid !== 1'b1)
      $display("FAIL abc latency: o_blk_valid got %b, required 1", bus0.o_blk_valid);
    else passed++;
    e_abc = '0;
    e_abc[511:480] = 32'h61626380;
    e_abc[63:0] = 64'h18;
    total++;
    if (bus0.o_blk !== e_abc)
      $display("FAIL abc block: got top %h low %h, required top 61626380 low 18",
               bus0.o_blk[511:480], bus0.o_blk[63:0]);
    else passed++;
    check_msg(0, 3, "abc");
  endtask

  task automatic test_empty();
    send_msg(0, 0);
    check_msg(0, 0, "empty");
    if (got0.size() > 0) begin
      total++;
      if (got0[0].blk[511:0] !== {8'h80, 504'h0})
        $display("FAIL empty block: got top %h low %h, required top 80000000 low 0",
                 got0[0].blk[511:480], got0[0].blk[63:0]);
      else passed++;
    end
  endtask

  task automatic test_boundaries();
    int lens [6] = '{55, 56, 60, 63, 64, 68};
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < 256; i++) msg[i] = 8'($urandom);
      send_msg(0, lens[t]);
      check_msg(0, lens[t], $sformatf("len%0d", lens[t]));
    end
  endtask

  task automatic test_random();
    int len;
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(0, 200);
      for (int i = 0; i < 256; i++) msg[i] = 8'($urandom);
      send_msg(0, len);
      check_msg(0, len, $sformatf("rnd256_len%0d", len));
    end
  endtask

  task automatic test_sha512();
    int lens [4] = '{112, 111, 128, 0};
    lens[3] = $urandom_range(1, 250);
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 256; i++) msg[i] = 8'($urandom);
      send_msg(1, lens[t]);
      check_msg(1, lens[t], $sformatf("sha512_len%0d", lens[t]));
      if (t == 0 && got1.size() == 2) begin
        total++;
        if (got1[1].blk[127:0] !== 128'h380)
          $display("FAIL sha512_112 length field: got %h, required 380", got1[1].blk[127:0]);
        else passed++;
      end
    end
  endtask

  task automatic test_stall();
    logic [511:0] snap;
    int n = 0;
    for (int i = 0; i < 256; i++) msg[i] = 8'($urandom);
    bus0.i_blk_ready = 1'b0;
    send_msg(0, 40);
    while (bus0.o_blk_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    snap = bus0.o_blk;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (bus0.o_blk !== snap || bus0.o_ready !== 1'b0 || bus0.o_blk_valid !== 1'b1)
        $display("FAIL stall cycle %0d: got vld=%b rdy=%b stable=%b, required 1 0 1", c,
                 bus0.o_blk_valid, bus0.o_ready, bus0.o_blk === snap);
      else passed++;
    end
    @(posedge clk);
    #1 bus0.i_blk_ready = 1'b1;
    check_msg(0, 40, "stall");
  endtask

  task automatic test_reset_mid();
    got0.delete();
    bus0.i_blk_ready = 1'b0;
    for (int k = 0; k < 16; k++) send_word(0, $urandom | 32'h1, 1'b0, 3'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset_mid");
    rst_n = 1'b1;
    bus0.i_blk_ready = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (got0.size() != 0)
      $display("FAIL reset_mid aborted block: got %0d blocks, required 0", got0.size());
    else passed++;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(0, 3);
    check_msg(0, 3, "abc_after_reset");
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_boundaries();
    test_random();
    test_sha512();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
